// File: rtl/fifo_pad_if.sv
// Purpose: pad-level push/pop bundle between a producer/consumer and fifo_pad.
// Latency: none; wires only.
// Backpressure: o_full_pad / o_empty_pad tell the master when pushes/pops will be dropped.
// Ports (signals): i_wr_en_pad, i_wr_data_pad, i_rd_en_pad driven by master;
//                  o_rd_data_pad, o_full_pad, o_empty_pad driven by the FIFO (slave).
interface fifo_pad_if #(
    parameter int DATASIZE = 8
);
    logic                i_wr_en_pad;
    logic [DATASIZE-1:0] i_wr_data_pad;
    logic                i_rd_en_pad;
    logic [DATASIZE-1:0] o_rd_data_pad;
    logic                o_full_pad;
    logic                o_empty_pad;

    modport master (
        output i_wr_en_pad,
        output i_wr_data_pad,
        output i_rd_en_pad,
        input  o_rd_data_pad,
        input  o_full_pad,
        input  o_empty_pad
    );

    modport slave (
        input  i_wr_en_pad,
        input  i_wr_data_pad,
        input  i_rd_en_pad,
        output o_rd_data_pad,
        output o_full_pad,
        output o_empty_pad
    );
endinterface

// File: rtl/fifo_pad.sv
// Purpose: single-clock first-word-fall-through FIFO used as the chip-top data buffer.
// Latency: a word pushed at edge N is on o_rd_data_pad right after edge N; next word one cycle after a pop.
// Backpressure: push while full and pop while empty are silently dropped; flags come from registered pointers.
// Ports: i_clk_pad (clock), i_rst_n_pad (async active-low reset),
//        pad (fifo_pad_if.slave: push enable/data, pop enable, head data, full, empty).
module fifo_pad #(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 4,
    parameter int MEM_DEPTH = 16
) (
    input  logic         i_clk_pad,
    input  logic         i_rst_n_pad,
    fifo_pad_if.slave    pad
);

    // Reset assertion is immediate; release is delayed through two flops so
    // the pointer flops leave reset synchronously to i_clk_pad.
    logic [1:0] rst_sync;
    logic       rst_live_n;

    always_ff @(posedge i_clk_pad or negedge i_rst_n_pad) begin
        if (!i_rst_n_pad) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_live_n = rst_sync[1];

    // Extra MSB on each pointer is the wrap bit that separates full from empty.
    logic [ADDRSIZE:0]   wr_ptr;
    logic [ADDRSIZE:0]   rd_ptr;
    logic [DATASIZE-1:0] mem [MEM_DEPTH];
    logic                empty;
    logic                full;
    logic                wr_fire;
    logic                rd_fire;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDRSIZE-1:0] == rd_ptr[ADDRSIZE-1:0]) &&
                   (wr_ptr[ADDRSIZE] != rd_ptr[ADDRSIZE]);

    // Both decisions use pre-edge flags, so a pop on a full FIFO frees a slot
    // only for the following cycle, and a push on an empty one cannot be popped
    // in the same cycle.
    assign wr_fire = pad.i_wr_en_pad && !full && rst_live_n;
    assign rd_fire = pad.i_rd_en_pad && !empty;

    always_ff @(posedge i_clk_pad or negedge rst_live_n) begin
        if (!rst_live_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + (ADDRSIZE+1)'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + (ADDRSIZE+1)'(1);
            end
        end
    end

    // Storage carries no reset; stale words are hidden by the empty gate below.
    always_ff @(posedge i_clk_pad) begin
        if (wr_fire) begin
            mem[wr_ptr[ADDRSIZE-1:0]] <= pad.i_wr_data_pad;
        end
    end

    assign pad.o_rd_data_pad = empty ? '0 : mem[rd_ptr[ADDRSIZE-1:0]];
    assign pad.o_full_pad    = full;
    assign pad.o_empty_pad   = empty;

endmodule

// File: tb/tb_fifo_pad.sv
// Purpose: self-checking bench for fifo_pad with a queue scoreboard and a pop monitor.
// Latency: checks zero-cycle fall-through and per-cycle flag/head values.
// Backpressure: exercises drop-on-full, ignore-on-empty and simultaneous push/pop.
module tb_fifo_pad;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    fifo_pad_if #(.DATASIZE(DW)) bus ();

    fifo_pad #(
        .DATASIZE (DW),
        .ADDRSIZE (4),
        .MEM_DEPTH(DEPTH)
    ) dut (
        .i_clk_pad  (clk),
        .i_rst_n_pad(rst_n),
        .pad        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    int model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: just before each edge, a pop the DUT will perform is checked
    // against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus.i_rd_en_pad && !bus.o_empty_pad) begin
            if (exp_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL pop_unexpected: got=0x%0h want=none", bus.o_rd_data_pad);
            end else begin
                chk("pop_data", 32'(bus.o_rd_data_pad), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus: drive, predict acceptance from the model count
    // (pre-edge), then check flags and head after the edge.
    task automatic cyc(input logic wr, input logic [DW-1:0] d, input logic rd);
        logic wr_ok;
        logic rd_ok;
        bus.i_wr_en_pad   = wr;
        bus.i_wr_data_pad = d;
        bus.i_rd_en_pad   = rd;
        wr_ok = wr && (model_cnt < DEPTH);
        rd_ok = rd && (model_cnt > 0);
        if (wr_ok) exp_q.push_back(d);
        @(posedge clk);
        #1;
        model_cnt = model_cnt + int'(wr_ok) - int'(rd_ok);
        bus.i_wr_en_pad = 1'b0;
        bus.i_rd_en_pad = 1'b0;
        chk("empty", 32'(bus.o_empty_pad), 32'(model_cnt == 0));
        chk("full",  32'(bus.o_full_pad),  32'(model_cnt == DEPTH));
        if (model_cnt > 0 && exp_q.size() > 0)
            chk("head", 32'(bus.o_rd_data_pad), 32'(exp_q[0]));
        else
            chk("head_zero", 32'(bus.o_rd_data_pad), 32'h0);
    endtask

    logic [DW-1:0] vec3 [3]  = '{8'h24, 8'h81, 8'h09};
    logic [DW-1:0] vec16[16] = '{8'h3a, 8'hc5, 8'h11, 8'h7e, 8'h90, 8'h02, 8'hdb, 8'h46,
                                 8'ha8, 8'h5f, 8'he3, 8'h1c, 8'h67, 8'hb4, 8'h08, 8'hfe};

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.i_wr_en_pad   = 1'b1;
        bus.i_wr_data_pad = 8'h55;
        bus.i_rd_en_pad   = 1'b0;

        // 1: reset hold with a push request asserted, then release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 32'(bus.o_empty_pad), 32'h1);
        chk("rst_full",  32'(bus.o_full_pad),  32'h0);
        chk("rst_data",  32'(bus.o_rd_data_pad), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_edge1_empty", 32'(bus.o_empty_pad), 32'h1);
        bus.i_wr_en_pad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rel_idle_empty", 32'(bus.o_empty_pad), 32'h1);

        // 2: three writes, then three pops
        foreach (vec3[i]) cyc(1'b1, vec3[i], 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b1);
        chk("t2_empty", 32'(bus.o_empty_pad), 32'h1);

        // 3: fill, dropped 17th write, drain
        foreach (vec16[i]) cyc(1'b1, vec16[i], 1'b0);
        chk("t3_full", 32'(bus.o_full_pad), 32'h1);
        cyc(1'b1, 8'hff, 1'b0);
        repeat (16) cyc(1'b0, 8'h00, 1'b1);

        // 4: wrap-around, 3 x (10 writes, 10 reads)
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++) cyc(1'b1, DW'(8'h40 + r*16 + k), 1'b0);
            for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00, 1'b1);
        end

        // 5a: simultaneous push/pop while full -> 15 words, not full
        for (int k = 0; k < 16; k++) cyc(1'b1, DW'(8'hb0 + k), 1'b0);
        cyc(1'b1, 8'hee, 1'b1);
        chk("t5_full_cnt", 32'(model_cnt), 32'd15);
        repeat (15) cyc(1'b0, 8'h00, 1'b1);
        // 5b: simultaneous push/pop while empty -> 1 word, head is the new word
        cyc(1'b1, 8'h3c, 1'b1);
        chk("t5_empty_data", 32'(bus.o_rd_data_pad), 32'h3c);
        // 5c: half-full, count unchanged
        for (int k = 0; k < 7; k++) cyc(1'b1, DW'(8'h70 + k), 1'b0);
        cyc(1'b1, 8'h99, 1'b1);
        chk("t5_half_cnt", 32'(model_cnt), 32'd8);
        repeat (3) cyc(1'b0, 8'h00, 1'b1);

        // 6: asynchronous reset with 5 words stored
        chk("t6_pre_empty", 32'(bus.o_empty_pad), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_empty", 32'(bus.o_empty_pad), 32'h1);
        chk("t6_async_full",  32'(bus.o_full_pad),  32'h0);
        chk("t6_async_data",  32'(bus.o_rd_data_pad), 32'h0);
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h5a, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
